cluster_clock_gate_ctrl: RTL and testbench

Idle-detection and clock-gate enable controller that directly drives the enable input of the cluster clock-gating cell.
- Runs on the free-running (ungated) clock.
- Counts consecutive idle cycles of the cluster, then performs a drain request/acknowledge handshake with the cluster.
- Only after the handshake completes does it deassert the clock enable.
- On any wake event it re-enables the clock and holds the cluster in drain for a fixed settle delay before releasing it.

---
 rtl/cluster_clock_gate_ctrl.sv | 139 +++++++++++++
 tb/tb_cluster_clock_gate_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_clock_gate_ctrl.sv
// Idle-detect / drain-handshake controller driving the cluster clock-gate enable.
// Optional gated-cycle statistics counter: define CLK_GATE_STATS_EN.
module cluster_clock_gate_ctrl #(
    parameter int unsigned IDLE_CNT_W = 8,
    parameter int unsigned WAKE_DLY   = 2,
    parameter int unsigned STAT_W     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic [IDLE_CNT_W-1:0] idle_thr_i,
    input  logic                  busy_i,
    input  logic                  wake_i,
    input  logic                  drain_ack_i,
    output logic                  drain_req_o,
    output logic                  clk_en_o,
    output logic                  gated_o
`ifdef CLK_GATE_STATS_EN
    ,
    input  logic                  stat_clr_i,
    output logic [STAT_W-1:0]     gated_cycles_o
`endif
);

    localparam int unsigned WAKE_W = (WAKE_DLY > 1) ? $clog2(WAKE_DLY) : 1;

    typedef enum logic [2:0] {
        ST_ACTIVE = 3'd0,
        ST_COUNT  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_GATED  = 3'd3,
        ST_WAKE   = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [WAKE_W-1:0]     wake_cnt_q, wake_cnt_d;
    logic                  clk_en_q, clk_en_d;
    logic                  drain_req_q, drain_req_d;
    logic                  gated_q, gated_d;
    logic                  abort;

    always_comb begin
        abort      = busy_i | wake_i | ~enable_i;
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        case (state_q)
            ST_ACTIVE: begin
                if (!abort) begin
                    state_d    = ST_COUNT;
                    idle_cnt_d = '0;
                end
            end
            ST_COUNT: begin
                if (abort) begin
                    state_d = ST_ACTIVE;
                end else if (idle_cnt_q == idle_thr_i) begin
                    state_d = ST_DRAIN;
                end else if (idle_cnt_q != '1) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // a late ack racing an abort is deliberately dropped
                if (abort) begin
                    state_d = ST_ACTIVE;
                end else if (drain_ack_i) begin
                    state_d = ST_GATED;
                end
            end
            ST_GATED: begin
                if (abort) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = '0;
                end
            end
            ST_WAKE: begin
                if (wake_cnt_q == WAKE_W'(WAKE_DLY - 1)) begin
                    state_d = ST_ACTIVE;
                end else begin
                    wake_cnt_d = wake_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
        // outputs decoded from the next state so they are registered
        clk_en_d    = (state_d != ST_GATED);
        drain_req_d = (state_d == ST_DRAIN) || (state_d == ST_GATED) ||
                      (state_d == ST_WAKE);
        gated_d     = (state_d == ST_GATED) || (state_d == ST_WAKE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_ACTIVE;
            idle_cnt_q  <= '0;
            wake_cnt_q  <= '0;
            clk_en_q    <= 1'b1;
            drain_req_q <= 1'b0;
            gated_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            wake_cnt_q  <= wake_cnt_d;
            clk_en_q    <= clk_en_d;
            drain_req_q <= drain_req_d;
            gated_q     <= gated_d;
        end
    end

    assign clk_en_o    = clk_en_q;
    assign drain_req_o = drain_req_q;
    assign gated_o     = gated_q;

`ifdef CLK_GATE_STATS_EN
    logic [STAT_W-1:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (stat_clr_i) begin
            stat_d = '0;
        end else if (state_q == ST_GATED && stat_q != '1) begin
            stat_d = stat_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign gated_cycles_o = stat_q;
`endif

endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// Scoreboard bench for cluster_clock_gate_ctrl: a cycle model pushes the
// expected outputs per driven cycle, popped and compared after each edge.
module tb_cluster_clock_gate_ctrl;

    localparam int WAKE_DLY = 2;
    localparam int STAT_MAX = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] thr;
    logic       busy;
    logic       wake;
    logic       ack;
    logic       clr;
    logic       drain_req;
    logic       clk_en;
    logic       gated;
    logic [7:0] gcyc;

    typedef struct packed {
        logic       ce;
        logic       dr;
        logic       g;
        logic [7:0] st;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   m_st, m_icnt, m_wcnt, m_stat;

    cluster_clock_gate_ctrl #(
        .IDLE_CNT_W(8),
        .WAKE_DLY  (WAKE_DLY),
        .STAT_W    (8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .enable_i   (en),
        .idle_thr_i (thr),
        .busy_i     (busy),
        .wake_i     (wake),
        .drain_ack_i(ack),
        .drain_req_o(drain_req),
        .clk_en_o   (clk_en),
        .gated_o    (gated)
`ifdef CLK_GATE_STATS_EN
        ,
        .stat_clr_i    (clr),
        .gated_cycles_o(gcyc)
`endif
    );

`ifndef CLK_GATE_STATS_EN
    assign gcyc = 8'd0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st   = 0;
        m_icnt = 0;
        m_wcnt = 0;
        m_stat = 0;
    endtask

    task automatic step();
        exp_t e;
        bit   ab;
        ab = busy | wake | !en;
        if (clr) m_stat = 0;
        else if (m_st == 3 && m_stat < STAT_MAX) m_stat++;
        case (m_st)
            0: if (!ab) begin m_st = 1; m_icnt = 0; end
            1: begin
                if (ab) m_st = 0;
                else if (m_icnt == int'(thr)) m_st = 2;
                else if (m_icnt < 255) m_icnt++;
            end
            2: if (ab) m_st = 0; else if (ack) m_st = 3;
            3: if (ab) begin m_st = 4; m_wcnt = 0; end
            default: begin
                m_wcnt++;
                if (m_wcnt == WAKE_DLY) m_st = 0;
            end
        endcase
        e.ce = (m_st != 3);
        e.dr = (m_st >= 2);
        e.g  = (m_st >= 3);
        e.st = 8'(m_stat);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("clk_en", 32'(clk_en), 32'(e.ce));
        chk("drain_req", 32'(drain_req), 32'(e.dr));
        chk("gated", 32'(gated), 32'(e.g));
`ifdef CLK_GATE_STATS_EN
        chk("gated_cycles", 32'(gcyc), 32'(e.st));
`endif
    endtask

    task automatic reach(input int target, input string tag);
        int n;
        n = 0;
        while (m_st != target && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(m_st), 32'(target));
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        en    = 1'b1;
        thr   = 8'd3;
        busy  = 1'b0;
        wake  = 1'b0;
        ack   = 1'b1;
        clr   = 1'b0;
        model_reset();
        #12;
        chk("rst_clk_en", 32'(clk_en), 32'd1);
        chk("rst_drain_req", 32'(drain_req), 32'd0);
        chk("rst_gated", 32'(gated), 32'd0);
`ifdef CLK_GATE_STATS_EN
        chk("rst_stat", 32'(gcyc), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // idle run with thr=3 and ack tied high
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 4) chk("t1_drain_early", 32'(drain_req), 32'd0);
            if (k == 5) chk("t1_drain_rise", 32'(drain_req), 32'd1);
            if (k == 5) chk("t1_clk_still_on", 32'(clk_en), 32'd1);
            if (k == 6) chk("t1_clk_off", 32'(clk_en), 32'd0);
            if (k == 6) chk("t1_gated", 32'(gated), 32'd1);
        end

        // wake pulse from GATED
        step();
        step();
        wake = 1'b1;
        step();
        chk("t2_clk_on", 32'(clk_en), 32'd1);
        wake = 1'b0;
        step();
        chk("t2_drain_held", 32'(drain_req), 32'd1);
        step();
        chk("t2_drain_fall", 32'(drain_req), 32'd0);
        chk("t2_gated_fall", 32'(gated), 32'd0);

        // busy and ack together in DRAIN
        ack = 1'b0;
        thr = 8'd2;
        reach(2, "t3_reach_drain");
        busy = 1'b1;
        ack  = 1'b1;
        step();
        chk("t3_drain_drop", 32'(drain_req), 32'd0);
        chk("t3_clk_on", 32'(clk_en), 32'd1);
        ack = 1'b0;
        step();

        // restart of the idle count at count 7, thr=10
        busy = 1'b0;
        thr  = 8'd10;
        for (int k = 0; k < 8; k++) step();
        chk("t4_cnt7", 32'(m_icnt), 32'd7);
        busy = 1'b1;
        step();
        busy = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!drain_req && n < 40);
        chk("t4_restart_len", 32'(n), 32'd12);

`ifdef CLK_GATE_STATS_EN
        ack = 1'b1;
        reach(3, "t5_reach_gated");
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int k = 0; k < 50; k++) step();
        chk("t5_stat50", 32'(gcyc), 32'd50);
        clr = 1'b1;
        step();
        chk("t5_stat_clr", 32'(gcyc), 32'd0);
        clr = 1'b0;
        for (int k = 0; k < 300; k++) step();
        chk("t5_stat_sat", 32'(gcyc), 32'(STAT_MAX));
        wake = 1'b1;
        step();
        wake = 1'b0;
        for (int k = 0; k < 3; k++) step();
`endif

        // enable low in GATED, then reset during WAKE
        ack = 1'b1;
        thr = 8'd0;
        reach(3, "t6_reach_gated");
        en = 1'b0;
        step();
        chk("t6_clk_on", 32'(clk_en), 32'd1);
        chk("t6_in_wake", 32'(gated), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_clk_en", 32'(clk_en), 32'd1);
        chk("t6_rst_drain", 32'(drain_req), 32'd0);
        chk("t6_rst_gated", 32'(gated), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("t6_rst_hold", 32'(clk_en), 32'd1);
        rst_n = 1'b1;
        en    = 1'b1;
        ack   = 1'b0;
        for (int k = 0; k < 4; k++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
